mt32_ctrl: RTL and testbench
============================

// Module: mt32_ctrl
// PURPOSE
//  Sequencer for the MT19937 core: seeds the 624x32 state RAM (init_genrand), pulses gen_init,
//  then exposes the generator as a valid/ready stream, converting consumer handshakes into
//  gen_update. Owns the RAM write port; generator read ports wire straight to the RAM.
// PARAMETERS
//  MT_N       624           state words
//  MT_AW      10            RAM address width
//  SEED_MULT  32'h6C078965  init_genrand multiplier (1812433253)
// PORTS
//  clk          in   1   single clock
//  reset        in   1   synchronous, active-high
//  seed         in   32  seed value, sampled with seed_load
//  seed_load    in   1   1-cycle pulse: (re)seed and restart
//  busy         out  1   high in SEED, INIT, WAIT
//  rnd_data     out  32  tempered output (= gen_dout)
//  rnd_valid    out  1   rnd_data valid
//  rnd_ready    in   1   consumer accepts when rnd_valid & rnd_ready
//  gen_init     out  1   to generator init
//  gen_update   out  1   to generator update
//  gen_dout     in   32  generator dout
//  gen_dout_en  in   1   generator dout_en
//  gen_waddr    in   10  generator write address
//  gen_wen      in   1   generator write enable
//  gen_wdata    in   32  generator write data
//  ram_waddr    out  10  state RAM write address
//  ram_wen      out  1   state RAM write enable
//  ram_wdata    out  32  state RAM write data
// BEHAVIOUR
//  Reset: state=IDLE; busy, rnd_valid, gen_init, gen_update, ram_wen = 0; ram_waddr, ram_wdata = 0.
//  FSM: IDLE -seed_load-> SEED -(idx==MT_N-1)-> INIT -(1 cyc)-> WAIT -gen_dout_en-> RUN.
//  seed_load sampled in ANY state (IDLE/SEED/INIT/WAIT/RUN) -> SEED next cycle; counter to 0,
//   prev <= seed; reset outranks seed_load.
//  SEED: one write per cycle, idx 0..MT_N-1; ram_waddr=idx; word(0)=seed;
//   word(i)=SEED_MULT*(w^(w>>30))+i, mod 2^32 (low 32 bits of product), w=word(i-1).
//  Latency: seed_load at edge k -> ram_wen cycles k+1..k+624 -> gen_init=1 in cycle k+625 only ->
//   WAIT k+626.. -> first rnd_valid at k+630 (generator prefetch 4 cycles).
//  RAM write mux: SEED drives controller word; all other states pass gen_waddr/gen_wen/gen_wdata.
//  rnd_valid = (state in WAIT,RUN) & gen_dout_en; stale gen_dout_en in IDLE/SEED/INIT is masked.
//  gen_update = rnd_valid & rnd_ready (combinational); 0 outside WAIT/RUN, so the generator
//   never writes the RAM during seeding.
//  rnd_data held stable while rnd_valid & !rnd_ready; no accept is lost or duplicated.
//  Back-to-back accepts: one word per cycle; generator's 624-wrap is transparent.
//  seed_load in RUN: rnd_valid drops next cycle; an in-flight accept that cycle still counts.
//  seed_load in SEED: restart at idx 0 with new seed; earlier partial writes are overwritten.
//  No seed_load after reset: stay IDLE, rnd_valid=0 indefinitely.
// STRUCTURE
//  mt32_pkg: MT_N, MT_AW, SEED_MULT, TEMPER constants, state enum (IDLE,SEED,INIT,WAIT,RUN).
//  Sub-module mt32_seed_seq: idx counter + prev register + multiplier; start/done/waddr/wdata/wen.
//  mt32_ctrl = FSM + RAM write mux + handshake glue; single 32x32 multiply, low half only.
// TESTING
//  1 reset, seed=5489 pulse -> RAM[0]=5489, RAM[1]=1301868182, ram_wen exactly 624 cycles.
//  2 same run, rnd_ready=1 -> first rnd_valid at k+630; data 3499211612, 581869302, 3890346734.
//  3 toggle rnd_ready randomly -> accepted sequence identical to test 2; data stable while stalled.
//  4 drain 1300 words (crosses 624 wrap twice) -> matches C reference init_genrand(5489).
//  5 seed_load=1 in RUN mid-stream, seed=1 -> rnd_valid low k+1..k+629; stream = genrand(seed 1).
//  6 reset during SEED at idx 300 -> IDLE, outputs 0; reseed 5489 -> test 2 sequence restored.

Source files
------------

// File: rtl/mt32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mt32_pkg                                                          |
// | Shared constants, state encoding and the init_genrand step function for    |
// | the MT19937 sequencer (mt32_ctrl, mt32_seed_seq, mt32_if).                 |
// |   MT_N       : number of 32-bit state words                                |
// |   MT_AW      : state RAM address width                                     |
// |   SEED_MULT  : init_genrand multiplier (1812433253)                        |
// |   TEMPER_*   : tempering masks used by the generator core                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mt32_pkg;

  localparam int          MT_N      = 624;
  localparam int          MT_AW     = 10;
  localparam logic [31:0] SEED_MULT = 32'h6C078965;
  localparam logic [31:0] TEMPER_B  = 32'h9D2C5680;
  localparam logic [31:0] TEMPER_C  = 32'hEFC60000;

  // Index of the final seed word; the seed walk stops after writing it.
  localparam logic [MT_AW-1:0] LAST_IDX = MT_AW'(MT_N - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    INIT = 3'd2,
    WAIT = 3'd3,
    RUN  = 3'd4
  } mt32_state_t;

  // word(i) = SEED_MULT * (w ^ (w >> 30)) + i, keeping only the low 32 bits.
  function automatic logic [31:0] seed_next(input logic [31:0] w,
                                            input logic [MT_AW-1:0] i);
    return (SEED_MULT * (w ^ (w >> 30))) + 32'(i);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mt32_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mt32_if                                                           |
// | Bundle of every non-clock signal of mt32_ctrl.                             |
// |   seed/seed_load            : seeding request from the host                |
// |   busy                      : sequencer is seeding or waiting for data     |
// |   rnd_data/valid/ready      : random-word stream to the consumer           |
// |   gen_init/gen_update       : commands to the MT19937 generator core       |
// |   gen_dout/gen_dout_en      : generator tempered output                    |
// |   gen_waddr/wen/wdata       : generator state write-back request           |
// |   ram_waddr/wen/wdata       : arbitrated state RAM write port              |
// | slave  = controller side, master = surrounding system side.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mt32_if;
  import mt32_pkg::*;

  logic [31:0]      seed;
  logic             seed_load;
  logic             busy;
  logic [31:0]      rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;
  logic             gen_init;
  logic             gen_update;
  logic [31:0]      gen_dout;
  logic             gen_dout_en;
  logic [MT_AW-1:0] gen_waddr;
  logic             gen_wen;
  logic [31:0]      gen_wdata;
  logic [MT_AW-1:0] ram_waddr;
  logic             ram_wen;
  logic [31:0]      ram_wdata;

  modport slave (
    input  seed, seed_load, rnd_ready,
    input  gen_dout, gen_dout_en, gen_waddr, gen_wen, gen_wdata,
    output busy, rnd_data, rnd_valid, gen_init, gen_update,
    output ram_waddr, ram_wen, ram_wdata
  );

  modport master (
    output seed, seed_load, rnd_ready,
    output gen_dout, gen_dout_en, gen_waddr, gen_wen, gen_wdata,
    input  busy, rnd_data, rnd_valid, gen_init, gen_update,
    input  ram_waddr, ram_wen, ram_wdata
  );

endinterface
`default_nettype wire

// File: rtl/mt32_seed_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mt32_seed_seq                                                     |
// | Walks init_genrand over the state RAM: one word per cycle, index 0..N-1.   |
// |   clk, reset : clock, synchronous active-high reset                        |
// |   start      : (re)start the walk at index 0 with 'seed'                   |
// |   seed       : seed value, captured on start                               |
// |   wen        : a word is being written this cycle                          |
// |   waddr      : word index                                                  |
// |   wdata      : word value                                                  |
// |   done       : final word is being written this cycle                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mt32_seed_seq
  import mt32_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      seed,
  output logic             wen,
  output logic [MT_AW-1:0] waddr,
  output logic [31:0]      wdata,
  output logic             done
);

  logic [MT_AW-1:0] r_idx;
  logic [31:0]      r_prev;   // word(r_idx), written this cycle
  logic             r_active;

  logic             w_last;
  logic [31:0]      w_next;

  always_comb begin
    w_last = (r_idx == LAST_IDX);
    // The only multiplier in the sequencer; the next word is ready one
    // cycle ahead so the walk sustains one write per cycle.
    w_next = seed_next(r_prev, r_idx + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_idx    <= '0;
      r_prev   <= '0;
    end else if (start) begin
      // A restart mid-walk simply rewrites from index 0.
      r_active <= 1'b1;
      r_idx    <= '0;
      r_prev   <= seed;
    end else if (r_active) begin
      if (w_last) begin
        r_active <= 1'b0;
      end else begin
        r_idx  <= r_idx + 1'b1;
        r_prev <= w_next;
      end
    end
  end

  always_comb begin
    wen   = r_active;
    waddr = r_idx;
    wdata = r_prev;
    done  = r_active & w_last;
  end

endmodule
`default_nettype wire

// File: rtl/mt32_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mt32_ctrl                                                         |
// | Sequencer for an MT19937 core. Seeds the 624x32 state RAM, pulses          |
// | gen_init, then exposes the generator as a valid/ready stream whose         |
// | accepts become gen_update. Owns the RAM write port.                        |
// |   clk   : single clock                                                     |
// |   reset : synchronous, active-high                                         |
// |   bus   : mt32_if.slave - seed request, stream, generator and RAM ports    |
// | States: IDLE -> SEED (624 writes) -> INIT (1 cycle) -> WAIT -> RUN.        |
// | seed_load from any state restarts at SEED.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mt32_ctrl
  import mt32_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  mt32_if.slave bus
);

  mt32_state_t      r_state;
  mt32_state_t      w_next_state;

  logic             w_seq_wen;
  logic [MT_AW-1:0] w_seq_waddr;
  logic [31:0]      w_seq_wdata;
  logic             w_seq_done;
  logic             w_stream;

  mt32_seed_seq u_seed_seq (
    .clk   (clk),
    .reset (reset),
    .start (bus.seed_load),
    .seed  (bus.seed),
    .wen   (w_seq_wen),
    .waddr (w_seq_waddr),
    .wdata (w_seq_wdata),
    .done  (w_seq_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; seed_load wins over every other transition.
  always_comb begin
    w_next_state = r_state;
    if (bus.seed_load) begin
      w_next_state = SEED;
    end else begin
      case (r_state)
        IDLE: w_next_state = IDLE;
        SEED: if (w_seq_done) w_next_state = INIT;
        INIT: w_next_state = WAIT;
        WAIT: if (bus.gen_dout_en) w_next_state = RUN;
        RUN:  w_next_state = RUN;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Outputs. gen_dout_en is only trusted once the generator has been
  // initialised (WAIT/RUN); any level left over from before a reseed is
  // masked so that no update can reach the RAM while it is being seeded.
  always_comb begin
    w_stream       = (r_state == WAIT) || (r_state == RUN);
    bus.busy       = (r_state == SEED) || (r_state == INIT) || (r_state == WAIT);
    bus.gen_init   = (r_state == INIT);
    bus.rnd_valid  = w_stream & bus.gen_dout_en;
    bus.gen_update = w_stream & bus.gen_dout_en & bus.rnd_ready;
    bus.rnd_data   = bus.gen_dout;

    if (r_state == SEED) begin
      bus.ram_wen   = w_seq_wen;
      bus.ram_waddr = w_seq_waddr;
      bus.ram_wdata = w_seq_wdata;
    end else begin
      bus.ram_wen   = bus.gen_wen;
      bus.ram_waddr = bus.gen_waddr;
      bus.ram_wdata = bus.gen_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mt32_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mt32_ctrl                                                      |
// | Bench for mt32_ctrl. Contains a state RAM, a behavioural MT19937 core      |
// | that reads the RAM directly and writes back through the controller mux,    |
// | and a batch-style reference MT19937 that predicts the accepted stream.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mt32_ctrl;
  import mt32_pkg::*;

  localparam int N = 624;
  localparam int M = 397;

  logic clk = 1'b0;
  logic reset;
  mt32_if bus ();

  mt32_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- MT19937 arithmetic ----------------
  function automatic logic [31:0] twist(input logic [31:0] hi, input logic [31:0] lo,
                                        input logic [31:0] far);
    logic [31:0] y;
    y = (hi & 32'h80000000) | (lo & 32'h7FFFFFFF);
    return far ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
  endfunction

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  // ---------------- reference: init_genrand + batch genrand ----------------
  logic [31:0] ref_init [N];
  logic [31:0] ref_mt   [N];
  int          ref_mti;

  task automatic ref_seed(input logic [31:0] s);
    ref_init[0] = s;
    for (int i = 1; i < N; i++)
      ref_init[i] = 32'd1812433253 * (ref_init[i-1] ^ (ref_init[i-1] >> 30)) + 32'(i);
    for (int i = 0; i < N; i++) ref_mt[i] = ref_init[i];
    ref_mti = N;
  endtask

  task automatic ref_next(output logic [31:0] r);
    if (ref_mti >= N) begin
      for (int k = 0; k < N; k++)
        ref_mt[k] = twist(ref_mt[k], ref_mt[(k + 1) % N], ref_mt[(k + M) % N]);
      ref_mti = 0;
    end
    r = temper(ref_mt[ref_mti]);
    ref_mti++;
  endtask

  // ---------------- state RAM + behavioural generator core ----------------
  logic [31:0] ram [N];
  int   g_ptr = 0;
  int   g_pre = 0;
  logic s_rst  = 1'b0;
  logic s_init = 1'b0;
  logic s_upd  = 1'b0;

  task automatic gen_produce();
    logic [31:0] v;
    v = twist(ram[g_ptr], ram[(g_ptr + 1) % N], ram[(g_ptr + M) % N]);
    bus.gen_waddr   = MT_AW'(g_ptr);
    bus.gen_wdata   = v;
    bus.gen_wen     = 1'b1;
    bus.gen_dout    = temper(v);
    bus.gen_dout_en = 1'b1;
  endtask

  initial begin
    bus.gen_dout    = '0;
    bus.gen_dout_en = 1'b0;
    bus.gen_waddr   = '0;
    bus.gen_wen     = 1'b0;
    bus.gen_wdata   = '0;
    forever begin
      @(posedge clk); #1;
      bus.gen_wen = 1'b0;
      if (s_rst) begin
        bus.gen_dout_en = 1'b0;
        bus.gen_waddr   = '0;
        bus.gen_wdata   = '0;
        bus.gen_dout    = '0;
        g_pre = 0;
      end else if (s_init) begin
        g_ptr = 0;
        g_pre = 4;
        bus.gen_dout_en = 1'b0;
      end else if (g_pre > 0) begin
        g_pre--;
        if (g_pre == 0) gen_produce();
      end else if (s_upd && bus.gen_dout_en) begin
        g_ptr = (g_ptr + 1) % N;
        gen_produce();
      end
    end
  end

  // ---------------- cycle model + compare ----------------
  logic        chk_en   = 1'b0;
  logic        m_active = 1'b0;
  int          m_t      = 0;     // cycles since seed_load was sampled
  logic        m_en     = 1'b0;  // generator output already seen since seeding
  logic        m_stall  = 1'b0;
  logic [31:0] m_held   = '0;
  logic [31:0] m_seed   = '0;
  int          m_acc    = 0;
  int          m_wcnt   = 0;
  logic [31:0] first3 [3];

  always @(negedge clk) begin : p_check
    logic        e_seed, e_init, e_stream, e_valid, e_busy;
    logic [31:0] w;
    e_valid = 1'b0;
    if (chk_en) begin
      e_seed   = m_active && (m_t >= 1) && (m_t <= N);
      e_init   = m_active && (m_t == N + 1);
      e_stream = m_active && (m_t >= N + 2);
      e_valid  = e_stream && (bus.gen_dout_en === 1'b1);
      e_busy   = e_seed || e_init || (e_stream && !m_en);

      chk("busy", bus.busy, e_busy);
      chk("gen_init", bus.gen_init, e_init);
      chk("rnd_valid", bus.rnd_valid, e_valid);
      chk("gen_update", bus.gen_update, e_valid && bus.rnd_ready);

      if (e_seed) begin
        chk("ram_wen_seed", bus.ram_wen, 1'b1);
        chk("ram_waddr_seed", bus.ram_waddr, m_t - 1);
        chk("ram_wdata_seed", bus.ram_wdata, ref_init[m_t - 1]);
      end else begin
        chk("ram_wen_pass", bus.ram_wen, bus.gen_wen);
        chk("ram_waddr_pass", bus.ram_waddr, bus.gen_waddr);
        chk("ram_wdata_pass", bus.ram_wdata, bus.gen_wdata);
      end
      if (m_active && m_t <= N && bus.ram_wen === 1'b1) m_wcnt++;

      if (e_init) begin
        chk("seed_write_cycles", m_wcnt, N);
        chk("ram0_is_seed", ram[0], m_seed);
        if (m_seed == 32'd5489) chk("ram1_seed5489", ram[1], 32'd1301868182);
      end

      if (e_valid && !m_en) chk("first_valid_cycle", m_t, N + 6);
      if (m_stall && e_valid) chk("stall_hold", bus.rnd_data, m_held);

      if (e_valid && bus.rnd_ready) begin
        ref_next(w);
        chk("rnd_data", bus.rnd_data, w);
        if (m_seed == 32'd5489 && m_acc < 3) first3[m_acc] = bus.rnd_data;
        m_acc++;
      end
      m_stall = e_valid && !bus.rnd_ready;
      m_held  = bus.rnd_data;
    end

    // RAM commit and generator command sampling for the coming edge
    if (bus.ram_wen === 1'b1) ram[bus.ram_waddr] = bus.ram_wdata;
    s_rst  = reset;
    s_init = bus.gen_init;
    s_upd  = bus.gen_update;

    // Model state for the next cycle; reset outranks seed_load
    if (reset) begin
      chk_en   = 1'b1;
      m_active = 1'b0;
      m_en     = 1'b0;
      m_stall  = 1'b0;
    end else if (bus.seed_load) begin
      m_active = 1'b1;
      m_t      = 1;
      m_en     = 1'b0;
      m_stall  = 1'b0;
      m_acc    = 0;
      m_wcnt   = 0;
      m_seed   = bus.seed;
      for (int i = 0; i < 3; i++) first3[i] = '0;
      ref_seed(bus.seed);
    end else if (m_active) begin
      if (e_valid) m_en = 1'b1;
      m_t++;
    end
  end

  // ---------------- stimulus ----------------
  logic ready_rand = 1'b0;

  task automatic step();
    @(posedge clk); #1;
    bus.rnd_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic pulse_seed(input logic [31:0] s);
    step();
    bus.seed      = s;
    bus.seed_load = 1'b1;
    step();
    bus.seed_load = 1'b0;
  endtask

  task automatic wait_accepts(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (m_acc < n && c < budget) begin
      step();
      c++;
    end
    chk(name, (m_acc >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_first3(input string tag);
    chk({tag, "_w0"}, first3[0], 32'd3499211612);
    chk({tag, "_w1"}, first3[1], 32'd581869302);
    chk({tag, "_w2"}, first3[2], 32'd3890346734);
  endtask

  initial begin
    reset         = 1'b1;
    bus.seed      = '0;
    bus.seed_load = 1'b0;
    bus.rnd_ready = 1'b1;
    repeat (4) step();
    reset = 1'b0;

    // no seed yet: must stay idle
    repeat (40) step();
    @(negedge clk);
    chk("idle_rnd_valid", bus.rnd_valid, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_ram_wen", bus.ram_wen, 1'b0);

    // seed 5489 with the consumer always ready
    pulse_seed(32'd5489);
    wait_accepts(20, 1000, "drain_first20");
    check_first3("seed5489_a");

    // random backpressure, cross the 624-word wrap twice
    ready_rand = 1'b1;
    wait_accepts(1300, 8000, "drain_1300");

    // reseed mid-stream with seed 1 (accept in flight on the same cycle)
    ready_rand = 1'b0;
    pulse_seed(32'd1);
    wait_accepts(700, 3000, "drain_seed1");

    // reseed while still seeding
    pulse_seed(32'd12345);
    repeat (100) step();
    pulse_seed(32'd5489);
    wait_accepts(5, 1000, "drain_restart_in_seed");
    check_first3("seed5489_b");

    // reset in the middle of seeding (index 300)
    pulse_seed(32'd777);
    begin
      int c;
      c = 0;
      while (m_t != 301 && c < 1000) begin
        step();
        c++;
      end
    end
    chk("reach_idx300", m_t, 301);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rnd_valid", bus.rnd_valid, 1'b0);
    chk("rst_gen_init", bus.gen_init, 1'b0);
    chk("rst_gen_update", bus.gen_update, 1'b0);
    chk("rst_ram_wen", bus.ram_wen, 1'b0);
    chk("rst_ram_waddr", bus.ram_waddr, 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
    repeat (30) step();
    pulse_seed(32'd5489);
    wait_accepts(3, 1000, "drain_after_reset");
    check_first3("seed5489_c");

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
